// File: rtl/fft_result_reader.sv
// ---------------------------------------------------------------------------
// fft_result_reader
//
// Streams the results of a radix-4 FFT out of its four result RAM banks.
// Points are read in bank-major order (k = bank*N_BANK + addr). The reads
// pass through an RD_LAT-deep valid pipeline that matches the RAM latency,
// then land in a small output FIFO that absorbs downstream back-pressure.
//
// Ports
//   iCLK, iRESET            clock, asynchronous active-high reset
//   iSTART                  one-cycle pulse, begins a readout (IDLE only)
//   oADDR_RD_0..3           per-bank read address; only the bank being read
//                           carries an address, the others are held at 0
//   iDATA_RE/IM_0..3        signed bank data, valid RD_LAT cycles after addr
//   oVALID / iREADY         output handshake (see below)
//   oDATA_RE / oDATA_IM     signed result word, passed through unmodified
//   oIDX                    point index of the presented word
//   oLAST                   presented word is point N-1
//   oBUSY                   readout in progress
//   oDONE                   one-cycle pulse after the final transfer
//   oSTATE                  debug view of the FSM state
//
// Handshake: a word transfers on a rising edge where oVALID and iREADY are
// both high. Once oVALID rises, it and the presented word stay constant
// until that transfer happens; iREADY may change freely.
// ---------------------------------------------------------------------------
module fft_result_reader #(
    parameter int N      = 4096,
    parameter int N_BANK = N / 4,
    parameter int A_BIT  = 10,
    parameter int D_BIT  = 17,
    parameter int RD_LAT = 2,
    parameter int DEPTH  = 4
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iSTART,
    output logic [A_BIT-1:0]        oADDR_RD_0,
    output logic [A_BIT-1:0]        oADDR_RD_1,
    output logic [A_BIT-1:0]        oADDR_RD_2,
    output logic [A_BIT-1:0]        oADDR_RD_3,
    input  logic signed [D_BIT-1:0] iDATA_RE_0,
    input  logic signed [D_BIT-1:0] iDATA_RE_1,
    input  logic signed [D_BIT-1:0] iDATA_RE_2,
    input  logic signed [D_BIT-1:0] iDATA_RE_3,
    input  logic signed [D_BIT-1:0] iDATA_IM_0,
    input  logic signed [D_BIT-1:0] iDATA_IM_1,
    input  logic signed [D_BIT-1:0] iDATA_IM_2,
    input  logic signed [D_BIT-1:0] iDATA_IM_3,
    output logic                    oVALID,
    input  logic                    iREADY,
    output logic signed [D_BIT-1:0] oDATA_RE,
    output logic signed [D_BIT-1:0] oDATA_IM,
    output logic [$clog2(N)-1:0]    oIDX,
    output logic                    oLAST,
    output logic                    oBUSY,
    output logic                    oDONE,
    output logic [1:0]              oSTATE
);

    localparam int I_BIT = $clog2(N);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CW    = $clog2(RD_LAT + DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        bank_q, bank_d;
    logic [A_BIT-1:0]  addr_q, addr_d;
    logic [I_BIT-1:0]  idx_q, idx_d;

    // Read-valid pipeline: one stage per cycle of RAM latency.
    logic [RD_LAT-1:0] pv_q;
    logic [1:0]        pb_q [RD_LAT];
    logic [I_BIT-1:0]  pi_q [RD_LAT];

    // Output FIFO.
    logic signed [D_BIT-1:0] f_re_q  [DEPTH];
    logic signed [D_BIT-1:0] f_im_q  [DEPTH];
    logic [I_BIT-1:0]        f_idx_q [DEPTH];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q;

    logic                    issue;
    logic                    credit_ok;
    logic [CW-1:0]           out_cnt;
    logic                    push, pop, valid;
    logic signed [D_BIT-1:0] exit_re, exit_im;
    logic [I_BIT-1:0]        head_idx;
    logic                    head_last;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Reads still in flight count against FIFO space, so every issued read
    // is guaranteed a slot when its data comes back.
    always_comb begin
        out_cnt = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            out_cnt = out_cnt + CW'(pv_q[i]);
        end
    end

    assign credit_ok = (out_cnt + CW'(count_q)) < CW'(DEPTH);
    assign issue     = (state_q == S_READ) && credit_ok;

    assign valid     = (count_q != '0);
    assign pop       = valid && iREADY;
    assign push      = pv_q[RD_LAT-1];
    assign head_idx  = f_idx_q[rd_ptr_q];
    assign head_last = (head_idx == I_BIT'(N - 1));

    // ------------------------------------------------------------------
    // FSM: next state and read counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (iSTART) begin
                    state_d = S_READ;
                    bank_d  = '0;
                    addr_d  = '0;
                    idx_d   = '0;
                end
            end
            S_READ: begin
                if (issue) begin
                    idx_d = idx_q + I_BIT'(1);
                    if (addr_q == A_BIT'(N_BANK - 1)) begin
                        addr_d = '0;
                        bank_d = bank_q + 2'd1;
                        if (bank_q == 2'd3) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        addr_d = addr_q + A_BIT'(1);
                    end
                end
            end
            S_DRAIN: begin
                // The last word can only leave once nothing is in flight.
                if (pop && head_last && (pv_q == '0)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q <= S_IDLE;
            bank_q  <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Bank addresses: only the bank being read this cycle sees an address.
    // ------------------------------------------------------------------
    always_comb begin
        oADDR_RD_0 = '0;
        oADDR_RD_1 = '0;
        oADDR_RD_2 = '0;
        oADDR_RD_3 = '0;
        if (issue) begin
            case (bank_q)
                2'd0:    oADDR_RD_0 = addr_q;
                2'd1:    oADDR_RD_1 = addr_q;
                2'd2:    oADDR_RD_2 = addr_q;
                default: oADDR_RD_3 = addr_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read-valid pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            pv_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pb_q[i] <= '0;
                pi_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= issue;
            pb_q[0] <= bank_q;
            pi_q[0] <= idx_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pb_q[i] <= pb_q[i-1];
                pi_q[i] <= pi_q[i-1];
            end
        end
    end

    // Pick the returning bank's data as the read leaves the pipeline.
    always_comb begin
        exit_re = iDATA_RE_0;
        exit_im = iDATA_IM_0;
        case (pb_q[RD_LAT-1])
            2'd1: begin
                exit_re = iDATA_RE_1;
                exit_im = iDATA_IM_1;
            end
            2'd2: begin
                exit_re = iDATA_RE_2;
                exit_im = iDATA_IM_2;
            end
            2'd3: begin
                exit_re = iDATA_RE_3;
                exit_im = iDATA_IM_3;
            end
            default: begin
                exit_re = iDATA_RE_0;
                exit_im = iDATA_IM_0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output FIFO (push and pop may complete in the same cycle)
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                f_re_q[i]  <= '0;
                f_im_q[i]  <= '0;
                f_idx_q[i] <= '0;
            end
        end else begin
            if (push) begin
                f_re_q[wr_ptr_q]  <= exit_re;
                f_im_q[wr_ptr_q]  <= exit_im;
                f_idx_q[wr_ptr_q] <= pi_q[RD_LAT-1];
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // A push into a full FIFO means the credit check is broken.
    assert property (@(posedge iCLK) disable iff (iRESET)
        !(push && (count_q == CNT_W'(DEPTH))));

    // ------------------------------------------------------------------
    // Outputs: data fields read as zero whenever no word is presented.
    // ------------------------------------------------------------------
    assign oVALID   = valid;
    assign oDATA_RE = valid ? f_re_q[rd_ptr_q] : '0;
    assign oDATA_IM = valid ? f_im_q[rd_ptr_q] : '0;
    assign oIDX     = valid ? head_idx : '0;
    assign oLAST    = valid && head_last;
    assign oBUSY    = (state_q == S_READ) || (state_q == S_DRAIN);
    assign oDONE    = (state_q == S_FIN);
    assign oSTATE   = state_q;

endmodule

// File: tb/tb_fft_result_reader.sv
`timescale 1ns/1ps
module tb_fft_result_reader;

  localparam int N      = 4096;
  localparam int N_BANK = 1024;
  localparam int A_BIT  = 10;
  localparam int D_BIT  = 17;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 4;
  localparam int I_BIT  = 12;
  localparam int W      = 1 + I_BIT + 2 * D_BIT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic                    iSTART, iREADY;
  logic [A_BIT-1:0]        addr0, addr1, addr2, addr3;
  logic signed [D_BIT-1:0] ram_re [4];
  logic signed [D_BIT-1:0] ram_im [4];
  logic                    oVALID, oLAST, oBUSY, oDONE;
  logic signed [D_BIT-1:0] oDATA_RE, oDATA_IM;
  logic [I_BIT-1:0]        oIDX;
  logic [1:0]              oSTATE;

  fft_result_reader #(
    .N(N), .N_BANK(N_BANK), .A_BIT(A_BIT), .D_BIT(D_BIT),
    .RD_LAT(RD_LAT), .DEPTH(DEPTH)
  ) dut (
    .iCLK(clk), .iRESET(rst), .iSTART(iSTART),
    .oADDR_RD_0(addr0), .oADDR_RD_1(addr1), .oADDR_RD_2(addr2), .oADDR_RD_3(addr3),
    .iDATA_RE_0(ram_re[0]), .iDATA_RE_1(ram_re[1]),
    .iDATA_RE_2(ram_re[2]), .iDATA_RE_3(ram_re[3]),
    .iDATA_IM_0(ram_im[0]), .iDATA_IM_1(ram_im[1]),
    .iDATA_IM_2(ram_im[2]), .iDATA_IM_3(ram_im[3]),
    .oVALID(oVALID), .iREADY(iREADY),
    .oDATA_RE(oDATA_RE), .oDATA_IM(oDATA_IM),
    .oIDX(oIDX), .oLAST(oLAST), .oBUSY(oBUSY), .oDONE(oDONE), .oSTATE(oSTATE)
  );

  // ---------------- RAM model: bank b word a = (b*1024+a, -(b*1024+a)), 2-cycle latency ----------------
  logic [A_BIT-1:0] addr_v  [4];
  logic [A_BIT-1:0] addr_d1 [4];
  assign addr_v[0] = addr0;
  assign addr_v[1] = addr1;
  assign addr_v[2] = addr2;
  assign addr_v[3] = addr3;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      addr_d1[b] <= addr_v[b];
      ram_re[b]  <= D_BIT'(b * N_BANK + int'(addr_d1[b]));
      ram_im[b]  <= -D_BIT'(b * N_BANK + int'(addr_d1[b]));
    end
  end

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_word;
  assign got_word = {oLAST, oIDX, oDATA_RE, oDATA_IM};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic fill_expected();
    logic signed [D_BIT-1:0] v;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      v = D_BIT'(k);
      exp_q.push_back({(k == N - 1), I_BIT'(k), v, -v});
    end
  endtask

  // ---------------- monitor (samples on the falling edge) ----------------
  int words_seen, done_cnt, first_cyc, last_cyc, done_cyc, start_cyc, hold_cnt;
  logic         hold_chk = 1'b0;
  logic [W-1:0] held_word;

  always @(negedge clk) begin : mon
    int nz;
    logic [W-1:0] e;
    if (rst) begin
      hold_chk = 1'b0;
    end else begin
      nz = int'(addr0 != '0) + int'(addr1 != '0) + int'(addr2 != '0) + int'(addr3 != '0);
      if (nz != 0) check("addr_one_bank", nz, 1);
      if (hold_chk) begin
        hold_cnt++;
        check("hold", {oVALID, got_word}, {1'b1, held_word});
      end
      if (oVALID && first_cyc < 0) first_cyc = cyc;
      if (oVALID && iREADY) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("word", got_word, e);
        end
        words_seen++;
        last_cyc = cyc;
      end
      hold_chk  = oVALID && !iREADY;
      held_word = got_word;
      if (oDONE) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver ----------------
  // mode 0: ready always high, 1: 20-cycle stall after 5th word,
  // 2: random ready, 3: extra iSTART pulses mid-readout, 4: reset at word 1000
  task automatic run_readout(input int mode);
    int guard, stall_left;
    bit stalled, p1, p2;
    guard = 0; stall_left = 0; stalled = 0; p1 = 0; p2 = 0;
    fill_expected();
    words_seen = 0; done_cnt = 0; first_cyc = -1; last_cyc = -1;
    done_cyc = -1; hold_cnt = 0;
    iREADY    = 1'b1;
    iSTART    = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    iSTART = 1'b0;
    check("busy_run", oBUSY, 1);
    while (done_cnt == 0 && guard < 20000) begin
      case (mode)
        1: begin
          if (words_seen == 5 && !stalled) begin
            stalled    = 1;
            stall_left = 20;
          end
          if (stall_left > 0) begin
            iREADY = 1'b0;
            stall_left--;
          end else begin
            iREADY = 1'b1;
          end
        end
        2: iREADY = 1'($urandom_range(0, 1));
        3: begin
          iSTART = 1'b0;
          if (words_seen >= 100 && !p1) begin
            p1 = 1; iSTART = 1'b1;
          end else if (words_seen >= 3000 && !p2) begin
            p2 = 1; iSTART = 1'b1;
          end
        end
        4: begin
          if (words_seen >= 1000) begin
            rst = 1'b1;
            #1;
            check("rst_mid_outs", {oVALID, oBUSY, oDONE, oLAST, oIDX, oDATA_RE, oDATA_IM}, 0);
            check("rst_mid_addrs", {addr0, addr1, addr2, addr3}, 0);
            check("rst_mid_words", words_seen, 1000);
            @(posedge clk); #1;
            rst = 1'b0;
            exp_q.delete();
            @(posedge clk); #1;
            return;
          end
        end
        default: iREADY = 1'b1;
      endcase
      @(posedge clk); #1;
      guard++;
    end
    iSTART = 1'b0;
    iREADY = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("words", words_seen, N);
    check("done_cnt", done_cnt, 1);
    check("done_gap", done_cyc - last_cyc, 1);
    check("busy_end", oBUSY, 0);
    check("exp_left", exp_q.size(), 0);
    if (mode == 0) begin
      check("first_lat", first_cyc - start_cyc, RD_LAT + 1);
      check("rate", last_cyc - first_cyc, N - 1);
    end
    if (mode == 1) check("stall_holds", hold_cnt, 20);
  endtask

  initial begin
    rst    = 1'b1;
    iSTART = 1'b0;
    iREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {oVALID, oBUSY, oDONE, oLAST, oIDX, oDATA_RE, oDATA_IM}, 0);
    check("rst_addrs", {addr0, addr1, addr2, addr3}, 0);
    check("rst_state", oSTATE, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_readout(0);
    run_readout(1);
    run_readout(2);
    run_readout(3);
    run_readout(4);
    run_readout(0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fft_result_reader.md
FFT_RESULT_READER -- requirements
Module: fft_result_reader

Parameters
REQ-001 SHALL have parameter N, default 4096, meaning FFT length in points.
REQ-002 SHALL have parameter N_BANK, default N/4, meaning words per RAM bank (radix-4, four banks).
REQ-003 SHALL have parameter A_BIT, default 10, meaning bank address width, log2(N_BANK).
REQ-004 SHALL have parameter D_BIT, default 17, meaning signed result width per component.
REQ-005 SHALL have parameter RD_LAT, default 2, meaning RAM read latency in cycles from address to data.
REQ-006 SHALL have parameter DEPTH, default 4, meaning output FIFO depth; DEPTH >= RD_LAT+1.

Interface
REQ-007 iCLK  in  1  sole clock, all state on rising edge.
REQ-008 iRESET  in  1  asynchronous, active-high reset.
REQ-009 iSTART  in  1  one-cycle pulse driven from FFT oRDY; begins readout.
REQ-010 oADDR_RD_0..3  out  A_BIT each  read address per RAM bank.
REQ-011 iDATA_RE_0..3 / iDATA_IM_0..3  in  D_BIT each  signed bank read data, valid RD_LAT cycles after address.
REQ-012 oVALID  out  1  output word valid.
REQ-013 iREADY  in  1  downstream accepts word.
REQ-014 oDATA_RE / oDATA_IM  out  D_BIT each  signed result.
REQ-015 oIDX  out  log2(N)  point index of output word.
REQ-016 oLAST  out  1  high with word oIDX = N-1.
REQ-017 oBUSY  out  1  high from accepted iSTART until final word transferred.
REQ-018 oDONE  out  1  one-cycle pulse after final transfer.

Function
REQ-019 SHALL read points in bank-major order: index k = bank*N_BANK + addr, bank 0..3 outer, addr 0..N_BANK-1 inner.
REQ-020 FSM states: IDLE, READ, DRAIN, FIN.
REQ-021 IDLE -> READ on iSTART; iSTART in any other state ignored.
REQ-022 READ: one read issued per cycle when (outstanding + FIFO count) < DEPTH; otherwise issue stalls.
REQ-023 Issued read drives selected bank address; unselected bank addresses held 0.
REQ-024 Address counter wraps N_BANK-1 -> 0 with bank increment; READ -> DRAIN after issuing bank 3, addr N_BANK-1.
REQ-025 Read-valid shift pipeline of RD_LAT stages carries bank select and index; at exit, selected bank RE/IM plus index pushed into FIFO.
REQ-026 Credit rule guarantees FIFO never overflows; push into full FIFO is a design error (assertion).
REQ-027 oVALID = FIFO not empty; head word presented; transfer when oVALID and iREADY.
REQ-028 Simultaneous push and pop: count unchanged, both complete in same cycle.
REQ-029 oVALID, once high, SHALL hold with stable data until transfer.
REQ-030 DRAIN -> FIN when pipeline empty and word N-1 transferred; FIN asserts oDONE one cycle -> IDLE.
REQ-031 With iREADY held high: first oVALID RD_LAT+1 cycles after iSTART; one word per cycle thereafter; N words total.
REQ-032 Data passed unmodified (no scaling, no sign change).

Reset
REQ-033 iRESET high: state IDLE, counters, pipeline and FIFO cleared; oVALID=0, oBUSY=0, oDONE=0, oLAST=0, oIDX=0, oDATA_RE/IM=0, oADDR_RD_0..3=0.
REQ-034 Reset mid-readout aborts immediately; no further words emitted; next iSTART restarts at k=0.

Verification
REQ-035 Bank b word a preloaded with RE=b*1024+a, IM=-(b*1024+a); iSTART, iREADY=1 -> 4096 words, oDATA_RE=oIDX, oDATA_IM=-oIDX, oLAST only at 4095, oDONE one cycle later.
REQ-036 iREADY low 20 cycles after 5th word -> oVALID held, word 5 stable, no more than DEPTH words buffered, none lost or duplicated.
REQ-037 iREADY random 50% -> output sequence identical to REQ-035, idx strictly 0..4095 ascending.
REQ-038 iSTART pulsed again mid-readout -> ignored, sequence unaffected, single oDONE.
REQ-039 iRESET asserted at word 1000 -> all outputs 0 same cycle; new iSTART -> first word oIDX=0.
REQ-040 Bank boundary: words 1023/1024, 2047/2048, 3071/3072 -> addresses wrap to 0, bank switches, data match REQ-035.
